// File: rtl/conv_window_sequencer_pkg.sv
// Shared types and sizes for the 3x3 convolution window sequencer.
// Taps are numbered k = 3*row + col with k = 0 the top-left pixel.
package conv_window_sequencer_pkg;

    localparam int KTAPS         = 9;
    localparam int PIX_W         = 8;
    localparam int WGT_W         = 8;
    localparam int RES_W         = 16;
    localparam int WADDR_K1_BASE = 9;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    function automatic int tap_idx(input int row, input int col);
        return 3 * row + col;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Two raster line buffers (rows y-2 and y-1) sharing one column index.
// A write shifts the column up: row A takes row B, row B takes the new pixel.
module conv_line_buffer
    import conv_window_sequencer_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int XW    = $clog2(IMG_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XW-1:0]    x_i,
    input  logic             we_i,
    input  logic [PIX_W-1:0] pix_i,
    output logic [PIX_W-1:0] row_a_o,
    output logic [PIX_W-1:0] row_b_o
);

    logic [PIX_W-1:0] row_a_q [IMG_W];
    logic [PIX_W-1:0] row_b_q [IMG_W];

    assign row_a_o = row_a_q[x_i];
    assign row_b_o = row_b_q[x_i];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < IMG_W; i++) begin
                row_a_q[i] <= '0;
                row_b_q[i] <= '0;
            end
        end else if (we_i) begin
            row_a_q[x_i] <= row_b_q[x_i];
            row_b_q[x_i] <= pix_i;
        end
    end

endmodule

// File: rtl/conv_window_sequencer.sv
// Raster pixel stream -> 3x3 sliding window for an external two-kernel synapse MAC.
// Emits one result pair per unpadded window position with valid/ready backpressure.
module conv_window_sequencer
    import conv_window_sequencer_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     wload,
    input  logic [4:0]               waddr,
    input  logic [WGT_W-1:0]         wdata,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic [PIX_W-1:0]         pix_data,
    output logic [KTAPS*PIX_W-1:0]   syn_image,
    output logic [KTAPS*WGT_W-1:0]   syn_w0,
    output logic [KTAPS*WGT_W-1:0]   syn_w1,
    input  logic [RES_W-1:0]         syn_out0,
    input  logic [RES_W-1:0]         syn_out1,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RES_W-1:0]         out_w0,
    output logic [RES_W-1:0]         out_w1,
    output logic [$clog2(IMG_W)-1:0] out_x,
    output logic [$clog2(IMG_H)-1:0] out_y,
    output logic                     busy,
    output logic                     done
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    state_t                  state_q;
    logic [XW-1:0]           x_q;
    logic [YW-1:0]           y_q;
    logic                    all_in_q;
    logic                    out_valid_q;
    logic [XW-1:0]           out_x_q;
    logic [YW-1:0]           out_y_q;
    logic [PIX_W-1:0]        win_q [KTAPS];
    logic signed [WGT_W-1:0] w0_q  [KTAPS];
    logic signed [WGT_W-1:0] w1_q  [KTAPS];

    logic             stall;
    logic             accept;
    logic             qual;
    logic             frame_last;
    logic             all_in_d;
    logic             out_valid_d;
    logic             wsel_ok;
    logic             wsel_k1;
    logic [3:0]       wtap;
    logic [PIX_W-1:0] row_a;
    logic [PIX_W-1:0] row_b;
    logic [PIX_W-1:0] col [3];

    // A stalled result freezes the window: no pixel may enter until it drains.
    assign stall       = out_valid_q && !out_ready;
    assign pix_ready   = (state_q == STREAM) && !all_in_q && !stall;
    assign accept      = pix_valid && pix_ready;
    assign qual        = accept && (x_q >= XW'(2)) && (y_q >= YW'(2));
    assign frame_last  = (x_q == X_LAST) && (y_q == Y_LAST);
    assign all_in_d    = all_in_q || (accept && frame_last);
    assign out_valid_d = qual || stall;

    assign wsel_ok = (waddr < 5'(WADDR_K1_BASE + KTAPS));
    assign wsel_k1 = (waddr >= 5'(WADDR_K1_BASE));
    assign wtap    = wsel_k1 ? 4'(waddr - 5'(WADDR_K1_BASE)) : waddr[3:0];

    conv_line_buffer #(
        .IMG_W (IMG_W),
        .XW    (XW)
    ) u_line_buffer (
        .clk     (clk),
        .rst     (rst),
        .x_i     (x_q),
        .we_i    (accept),
        .pix_i   (pix_data),
        .row_a_o (row_a),
        .row_b_o (row_b)
    );

    assign col[0] = row_a;
    assign col[1] = row_b;
    assign col[2] = pix_data;

    always_comb begin
        for (int k = 0; k < KTAPS; k++) begin
            syn_image[PIX_W*k +: PIX_W] = win_q[k];
            syn_w0[WGT_W*k +: WGT_W]    = w0_q[k];
            syn_w1[WGT_W*k +: WGT_W]    = w1_q[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            all_in_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            for (int k = 0; k < KTAPS; k++) begin
                win_q[k] <= '0;
                w0_q[k]  <= '0;
                w1_q[k]  <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            if (qual) begin
                out_x_q <= x_q - XW'(2);
                out_y_q <= y_q - YW'(2);
            end
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[tap_idx(r, 0)] <= win_q[tap_idx(r, 1)];
                    win_q[tap_idx(r, 1)] <= win_q[tap_idx(r, 2)];
                    win_q[tap_idx(r, 2)] <= col[r];
                end
                if (x_q == X_LAST) begin
                    x_q <= '0;
                    y_q <= y_q + 1'b1;
                end else begin
                    x_q <= x_q + 1'b1;
                end
            end
            case (state_q)
                IDLE: begin
                    if (wload && wsel_ok) begin
                        if (wsel_k1) w1_q[wtap] <= wdata;
                        else         w0_q[wtap] <= wdata;
                    end
                    if (start) begin
                        state_q  <= STREAM;
                        x_q      <= '0;
                        y_q      <= '0;
                        all_in_q <= 1'b0;
                    end
                end
                STREAM: begin
                    all_in_q <= all_in_d;
                    // Finish only once every pixel is in and the final result has left.
                    if (all_in_d && !out_valid_d) state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_w0    = out_valid_q ? syn_out0 : '0;
    assign out_w1    = out_valid_q ? syn_out1 : '0;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Self-checking bench: randomized stream against a raster-image reference model,
// with a combinational synapse model attached to the DUT's synapse ports.
module tb_conv_window_sequencer;

    localparam int W    = 5;
    localparam int H    = 5;
    localparam int NPIX = W * H;
    localparam int NOUT = (W - 2) * (H - 2);
    localparam int XW   = $clog2(W);
    localparam int YW   = $clog2(H);

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        int          x;
        int          y;
    } res_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          wload = 1'b0;
    logic [4:0]    waddr = '0;
    logic [7:0]    wdata = '0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [7:0]    pix_data = '0;
    logic [71:0]   syn_image;
    logic [71:0]   syn_w0;
    logic [71:0]   syn_w1;
    logic [15:0]   syn_out0;
    logic [15:0]   syn_out1;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [15:0]   out_w0;
    logic [15:0]   out_w1;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic          busy;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;

    // stimulus controls
    bit         vrand = 0;
    bit         rrand = 0;
    logic [7:0] src_q [$];

    // reference model state
    bit   model_idle = 1;
    bit   exp_ov = 0;
    bit   exp_done = 0;
    int   cnt = 0;
    int   popped = 0;
    int   frames_done = 0;
    int   img [NPIX];
    int   wm [18];
    res_t exp_q [$];
    res_t rec_q [$];
    res_t ref1 [$];

    always #5 clk = ~clk;

    function automatic logic [15:0] synapse(input logic [71:0] img_v, input logic [71:0] w_v);
        int acc;
        acc = 0;
        for (int k = 0; k < 9; k++)
            acc += int'(img_v[8*k +: 8]) * int'($signed(w_v[8*k +: 8]));
        return acc[15:0];
    endfunction

    assign syn_out0 = synapse(syn_image, syn_w0);
    assign syn_out1 = synapse(syn_image, syn_w1);

    conv_window_sequencer #(
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .wload     (wload),
        .waddr     (waddr),
        .wdata     (wdata),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .syn_image (syn_image),
        .syn_w0    (syn_w0),
        .syn_w1    (syn_w1),
        .syn_out0  (syn_out0),
        .syn_out1  (syn_out1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_w0    (out_w0),
        .out_w1    (out_w1),
        .out_x     (out_x),
        .out_y     (out_y),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Expected result straight from the raster image and the kernel taps.
    function automatic res_t expect_at(input int x0, input int y0);
        res_t r;
        int a0, a1, p;
        a0 = 0;
        a1 = 0;
        for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++) begin
                p = img[(y0 + rr) * W + x0 + cc];
                a0 += p * wm[3*rr + cc];
                a1 += p * wm[9 + 3*rr + cc];
            end
        r.w0 = a0[15:0];
        r.w1 = a1[15:0];
        r.x  = x0;
        r.y  = y0;
        return r;
    endfunction

    function automatic logic [71:0] pack_w(input int base);
        logic [71:0] v;
        for (int k = 0; k < 9; k++) v[8*k +: 8] = 8'(wm[base + k]);
        return v;
    endfunction

    // Compare process: checks every cycle at negedge, then advances the model.
    initial begin
        bit   e_pr, qual, nx_done;
        int   px, py;
        res_t r;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_idle = 1;
                exp_ov     = 0;
                exp_done   = 0;
                cnt        = 0;
                popped     = 0;
                exp_q.delete();
                for (int k = 0; k < 18; k++) wm[k] = 0;
            end else begin
                e_pr = !model_idle && (cnt < NPIX) && !(exp_ov && !out_ready);
                chk("out_valid", out_valid, exp_ov);
                chk("done", done, exp_done);
                chk("busy", busy, !model_idle);
                chk("pix_ready", pix_ready, e_pr);
                chk("weights", {syn_w0, syn_w1}, {pack_w(0), pack_w(9)});
                if (exp_ov) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL result_extra: got out_valid=1, required no pending result");
                    end else begin
                        chk("result", {out_w0, out_w1, 8'(out_x), 8'(out_y)},
                            {exp_q[0].w0, exp_q[0].w1, 8'(exp_q[0].x), 8'(exp_q[0].y)});
                    end
                end
                if (done) frames_done++;

                nx_done = 0;
                if (exp_ov && out_ready && exp_q.size() > 0) begin
                    r.w0 = out_w0;
                    r.w1 = out_w1;
                    r.x  = int'(out_x);
                    r.y  = int'(out_y);
                    rec_q.push_back(r);
                    void'(exp_q.pop_front());
                    popped++;
                    if (popped == NOUT) nx_done = 1;
                end
                qual = 0;
                if (pix_valid && e_pr) begin
                    px = cnt % W;
                    py = cnt / W;
                    img[cnt] = int'(pix_data);
                    if (px >= 2 && py >= 2) begin
                        exp_q.push_back(expect_at(px - 2, py - 2));
                        qual = 1;
                    end
                    cnt++;
                end
                exp_ov = qual || (exp_ov && !out_ready);
                if (model_idle && wload && waddr < 18) wm[waddr] = int'($signed(wdata));
                if (exp_done) begin
                    model_idle = 1;
                end else if (model_idle && start) begin
                    model_idle = 0;
                    cnt        = 0;
                    popped     = 0;
                end
                exp_done = nx_done;
            end
        end
    end

    // Pixel source and result consumer.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (src_q.size() > 0 && (!vrand || $urandom_range(0, 99) < 70)) begin
                pix_valid = 1'b1;
                pix_data  = src_q[0];
            end else begin
                pix_valid = 1'b0;
                pix_data  = $urandom_range(0, 255);
            end
            out_ready = rrand ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && pix_valid && pix_ready && src_q.size() > 0) void'(src_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_w(input int a, input int d);
        wload = 1'b1;
        waddr = 5'(a);
        wdata = 8'(d);
        tick();
        wload = 1'b0;
    endtask

    task automatic load_basic();
        for (int a = 0; a < 18; a++) write_w(a, (a == 4 || a >= 9) ? 1 : 0);
    endtask

    task automatic push_frame(input int kind);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                src_q.push_back(kind == 0 ? 8'(x + y) :
                                kind == 1 ? 8'd255 : 8'($urandom_range(0, 255)));
    endtask

    task automatic begin_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_frame();
        int n, f0;
        n  = 0;
        f0 = frames_done;
        while (frames_done == f0 && n < 2000) begin
            tick();
            n++;
        end
        if (frames_done == f0) begin
            n_tests++;
            n_fail++;
            $display("FAIL frame_timeout: got no done after %0d cycles, required a done pulse", n);
        end
    endtask

    task automatic run_frame();
        rec_q.delete();
        begin_frame();
        wait_frame();
    endtask

    task automatic cmp_ref(input string nm, input int offset);
        for (int i = 0; i < NOUT; i++) begin
            if (i + offset < rec_q.size())
                chk(nm, {rec_q[i+offset].w0, rec_q[i+offset].w1, 8'(rec_q[i+offset].x), 8'(rec_q[i+offset].y)},
                        {ref1[i].w0, ref1[i].w1, 8'(ref1[i].x), 8'(ref1[i].y)});
        end
    endtask

    initial begin
        int n;
        // reset state
        repeat (2) tick();
        chk("reset_ctrl", {pix_ready, out_valid, busy, done, 8'(out_x), 8'(out_y), out_w0, out_w1}, '0);
        chk("reset_syn", {syn_image, syn_w0, syn_w1}, '0);
        rst = 1'b0;
        tick();

        // centre-tap and box kernels on pix = x + y
        load_basic();
        push_frame(0);
        run_frame();
        chk("basic_count", rec_q.size(), NOUT);
        if (rec_q.size() == NOUT) begin
            chk("basic_r00", {rec_q[0].w0, rec_q[0].w1, 8'(rec_q[0].x), 8'(rec_q[0].y)}, {16'd2, 16'd18, 8'd0, 8'd0});
            chk("basic_r22", {rec_q[8].w0, rec_q[8].w1, 8'(rec_q[8].x), 8'(rec_q[8].y)}, {16'd6, 16'd54, 8'd2, 8'd2});
        end
        ref1 = rec_q;

        // extreme values: truncation of -293760
        for (int a = 0; a < 18; a++) write_w(a, 8'h80);
        push_frame(1);
        run_frame();
        chk("extreme_count", rec_q.size(), NOUT);
        foreach (rec_q[i]) chk("extreme_val", {rec_q[i].w0, rec_q[i].w1}, {16'h8480, 16'h8480});

        // random backpressure and gaps, same stimulus as the first frame
        load_basic();
        vrand = 1;
        rrand = 1;
        push_frame(0);
        run_frame();
        vrand = 0;
        rrand = 0;
        chk("bp_count", rec_q.size(), NOUT);
        cmp_ref("bp_replay", 0);

        // weight write and start while streaming are ignored
        push_frame(0);
        rec_q.delete();
        begin_frame();
        repeat (4) tick();
        wload = 1'b1;
        waddr = 5'd4;
        wdata = 8'd7;
        start = 1'b1;
        tick();
        wload = 1'b0;
        start = 1'b0;
        chk("stream_wload_tap4", syn_w0[39:32], 8'd1);
        wait_frame();
        chk("stream_wload_count", rec_q.size(), NOUT);
        push_frame(0);
        run_frame();
        cmp_ref("after_ignored_write", 0);

        // fully random weights, pixels and handshakes
        for (int a = 0; a < 18; a++) write_w(a, $urandom_range(0, 255));
        vrand = 1;
        rrand = 1;
        push_frame(2);
        run_frame();
        vrand = 0;
        rrand = 0;
        chk("random_count", rec_q.size(), NOUT);

        // asynchronous reset mid-frame
        load_basic();
        push_frame(0);
        rec_q.delete();
        begin_frame();
        n = 0;
        while (cnt < 12 && n < 500) begin
            tick();
            n++;
        end
        #2;
        rst = 1'b1;
        src_q.delete();
        #1;
        chk("midrst_ctrl", {pix_ready, out_valid, busy, done, 8'(out_x), 8'(out_y), out_w0, out_w1}, '0);
        chk("midrst_syn", {syn_image, syn_w0, syn_w1}, '0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_state", {busy, syn_w0, syn_w1}, '0);
        push_frame(0);
        run_frame();
        chk("post_rst_count", rec_q.size(), NOUT);
        foreach (rec_q[i]) chk("post_rst_zero", {rec_q[i].w0, rec_q[i].w1}, '0);

        // back-to-back frames with pix_valid held high
        load_basic();
        push_frame(0);
        push_frame(0);
        rec_q.delete();
        begin_frame();
        wait_frame();
        begin_frame();
        wait_frame();
        chk("b2b_count", rec_q.size(), 2 * NOUT);
        cmp_ref("b2b_frame1", 0);
        cmp_ref("b2b_frame2", NOUT);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
